irq_pending_reg: RTL and testbench

- Sticky interrupt-pending register bank that sits directly upstream of the OR-reduction gate.
- Captures rising edges on BUS_WIDTH event lines into pending bits and applies an enable mask.
- Drives the masked pending bus that the OR gate reduces to a single IRQ line.
- Also exposes a lowest-index-first claim/acknowledge handshake, a write-1-to-clear path and a sticky overflow flag.

---
 rtl/irq_pending_reg.sv | 96 +++++++++
 tb/tb_irq_pending_reg.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/irq_pending_reg.sv
// Sticky interrupt-pending bank: edge capture, mask, lowest-first claim.
// Define IRQ_SYNC_EN to add a 2-flop input synchronizer on evt_in.
module irq_pending_reg #(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned ID_WIDTH  = 5,
  parameter logic [BUS_WIDTH-1:0] MASK_RESET = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [BUS_WIDTH-1:0] evt_in,
  input  logic                 mask_wr,
  input  logic [BUS_WIDTH-1:0] mask_data,
  input  logic [BUS_WIDTH-1:0] clr,
  input  logic                 ovf_clr,
  input  logic                 claim_ack,
  output logic [BUS_WIDTH-1:0] pend_out,
  output logic [BUS_WIDTH-1:0] raw_pend,
  output logic                 claim_valid,
  output logic [ID_WIDTH-1:0]  claim_id,
  output logic                 ovf
);

  logic [BUS_WIDTH-1:0] pend_q, pend_d;
  logic [BUS_WIDTH-1:0] mask_q, mask_d;
  logic [BUS_WIDTH-1:0] prev_q;
  logic                 ovf_q, ovf_d;
  logic [BUS_WIDTH-1:0] evt_s;
  logic [BUS_WIDTH-1:0] rise;
  logic [BUS_WIDTH-1:0] ackvec;
  logic [BUS_WIDTH-1:0] kill;
  logic [ID_WIDTH-1:0]  id;

`ifdef IRQ_SYNC_EN
  logic [BUS_WIDTH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= evt_in;
      sync2_q <= sync1_q;
    end
  end

  assign evt_s = sync2_q;
`else
  assign evt_s = evt_in;
`endif

  assign rise     = evt_s & ~prev_q;
  assign pend_out = pend_q & mask_q;
  assign raw_pend = pend_q;

  assign claim_valid = |pend_out;
  assign claim_id    = id;
  assign ovf         = ovf_q;

  // Scan high to low so the lowest set index wins.
  always_comb begin
    id = '0;
    for (int i = BUS_WIDTH - 1; i >= 0; i--) begin
      if (pend_out[i]) id = ID_WIDTH'(i);
    end
  end

  always_comb begin
    ackvec = '0;
    if (claim_ack && claim_valid) ackvec[id] = 1'b1;
  end

  assign kill = clr | ackvec;

  always_comb begin
    pend_d = rise | (pend_q & ~kill);
    mask_d = mask_wr ? mask_data : mask_q;
    ovf_d  = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (|(rise & pend_q & ~kill)) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
      mask_q <= MASK_RESET;
      prev_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
      prev_q <= evt_s;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_irq_pending_reg.sv
// Directed bench for irq_pending_reg in its default (unsynchronized) build.
module tb_irq_pending_reg;

  logic        clk;
  logic        reset_n;
  logic [31:0] evt_in;
  logic        mask_wr;
  logic [31:0] mask_data;
  logic [31:0] clr;
  logic        ovf_clr;
  logic        claim_ack;
  logic [31:0] pend_out;
  logic [31:0] raw_pend;
  logic        claim_valid;
  logic [4:0]  claim_id;
  logic        ovf;

  int n_chk = 0;
  int n_err = 0;

  irq_pending_reg dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .evt_in     (evt_in),
    .mask_wr    (mask_wr),
    .mask_data  (mask_data),
    .clr        (clr),
    .ovf_clr    (ovf_clr),
    .claim_ack  (claim_ack),
    .pend_out   (pend_out),
    .raw_pend   (raw_pend),
    .claim_valid(claim_valid),
    .claim_id   (claim_id),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    evt_in    = '0;
    mask_wr   = 1'b0;
    mask_data = '0;
    clr       = '0;
    ovf_clr   = 1'b0;
    claim_ack = 1'b0;
    #12;
    check("rst_pend_out", pend_out, 32'h0);
    check("rst_raw", raw_pend, 32'h0);
    check("rst_valid", {31'b0, claim_valid}, 32'h0);
    check("rst_id", {27'b0, claim_id}, 32'h0);
    check("rst_ovf", {31'b0, ovf}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // single event on bit 3
    mask_wr = 1'b1; mask_data = 32'h0000_00FF;
    step();
    mask_wr = 1'b0;
    evt_in = 32'h8;
    step();
    check("b3_raw", raw_pend, 32'h8);
    check("b3_pend_out", pend_out, 32'h8);
    check("b3_valid", {31'b0, claim_valid}, 32'h1);
    check("b3_id", {27'b0, claim_id}, 32'd3);
    evt_in = '0;
    claim_ack = 1'b1;
    step();
    claim_ack = 1'b0;
    check("b3_ack_raw", raw_pend, 32'h0);

    // drain bits 2 and 5 in order
    evt_in = 32'h24;
    step();
    evt_in = '0;
    check("drain_id0", {27'b0, claim_id}, 32'd2);
    claim_ack = 1'b1;
    step();
    check("drain_id1", {27'b0, claim_id}, 32'd5);
    step();
    claim_ack = 1'b0;
    check("drain_pend_out", pend_out, 32'h0);
    check("drain_valid", {31'b0, claim_valid}, 32'h0);

    // rise beats clear; overflow set and clear
    evt_in = 32'h200;
    step();
    check("b9_raw", raw_pend, 32'h200);
    evt_in = '0;
    step();
    evt_in = 32'h200; clr = 32'h200;
    step();
    check("b9_clr_raw", raw_pend, 32'h200);
    check("b9_clr_ovf", {31'b0, ovf}, 32'h0);
    evt_in = '0; clr = '0;
    step();
    evt_in = 32'h200;
    step();
    check("b9_ovf_set", {31'b0, ovf}, 32'h1);
    evt_in = '0; ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("b9_ovf_clr", {31'b0, ovf}, 32'h0);

    // masked top bit, then unmask
    mask_wr = 1'b1; mask_data = 32'h0; clr = '1;
    step();
    mask_wr = 1'b0; clr = '0;
    check("clr_all_raw", raw_pend, 32'h0);
    evt_in = 32'h8000_0000;
    step();
    evt_in = '0;
    check("b31_raw", raw_pend, 32'h8000_0000);
    check("b31_masked", pend_out, 32'h0);
    mask_wr = 1'b1; mask_data = 32'h8000_0000;
    step();
    mask_wr = 1'b0;
    check("b31_pend_out", pend_out, 32'h8000_0000);
    check("b31_id", {27'b0, claim_id}, 32'd31);

    // all pending, full mask
    mask_wr = 1'b1; mask_data = '1; evt_in = '1;
    step();
    mask_wr = 1'b0;
    check("all_raw", raw_pend, 32'hFFFF_FFFF);
    check("all_id", {27'b0, claim_id}, 32'd0);
    check("all_ovf", {31'b0, ovf}, 32'h1);
    evt_in = '0;
    step();
    evt_in = 32'h10; clr = '1;
    step();
    evt_in = '0; clr = '0;
    check("clr_rise_raw", raw_pend, 32'h10);
    check("clr_rise_id", {27'b0, claim_id}, 32'd4);

    // async reset mid-cycle
    evt_in = '1;
    step();
    check("pre_rst_raw", raw_pend, 32'hFFFF_FFFF);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_raw", raw_pend, 32'h0);
    check("mid_rst_pend_out", pend_out, 32'h0);
    check("mid_rst_valid", {31'b0, claim_valid}, 32'h0);
    check("mid_rst_id", {27'b0, claim_id}, 32'h0);
    check("mid_rst_ovf", {31'b0, ovf}, 32'h0);
    evt_in = 32'h1;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("post_rst_raw", raw_pend, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
